// File: rtl/sram_fifo.sv
// sram_fifo: first-word-fall-through FIFO whose storage lives in an external
// 1r1w SRAM (1-cycle read latency, NEW_DATA read-during-write).
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   flush_en            discard all contents
//   enqueue_en/_value   push request and data
//   dequeue_en          pop the head
//   dequeue_value       head entry (valid while !empty)
//   empty, full         status
//   almost_full, count  occupancy status (registered state only)
//   sram_read_*         read port of the SRAM macro wrapper
//   sram_write_*        write port of the SRAM macro wrapper
module sram_fifo #(
   parameter int DATA_WIDTH            = 32,
   parameter int SIZE                  = 64,
   parameter int ALMOST_FULL_THRESHOLD = SIZE - 4,
   parameter int ADDR_WIDTH            = $clog2(SIZE)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush_en,
   input  logic                  enqueue_en,
   input  logic [DATA_WIDTH-1:0] enqueue_value,
   input  logic                  dequeue_en,
   output logic [DATA_WIDTH-1:0] dequeue_value,
   output logic                  empty,
   output logic                  full,
   output logic                  almost_full,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  sram_read_en,
   output logic [ADDR_WIDTH-1:0] sram_read_addr,
   input  logic [DATA_WIDTH-1:0] sram_read_data,
   output logic                  sram_write_en,
   output logic [ADDR_WIDTH-1:0] sram_write_addr,
   output logic [DATA_WIDTH-1:0] sram_write_data
);

   localparam logic [ADDR_WIDTH:0]   CNT_ONE  = 1;
   localparam logic [ADDR_WIDTH:0]   CNT_ZERO = '0;
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = 1;
   localparam logic [ADDR_WIDTH:0]   CNT_FULL = (ADDR_WIDTH+1)'(SIZE);
   localparam logic [ADDR_WIDTH:0]   CNT_AF   =
      (ADDR_WIDTH+1)'(ALMOST_FULL_THRESHOLD);

   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [ADDR_WIDTH:0]   mem_count;
   logic                  in_flight;
   logic                  out_valid;
   logic [DATA_WIDTH-1:0] out_reg;

   logic enq_acc;
   logic deq_acc;
   logic holding;
   logic read_issue;

   assign count = mem_count
                + {{ADDR_WIDTH{1'b0}}, out_valid}
                + {{ADDR_WIDTH{1'b0}}, in_flight};
   assign full        = (count == CNT_FULL);
   assign almost_full = (count >= CNT_AF);
   assign empty       = !(out_valid || in_flight);
   assign dequeue_value = out_valid ? out_reg : sram_read_data;

   always_comb begin
      enq_acc = enqueue_en && !full && !flush_en && !reset;
      deq_acc = dequeue_en && !empty && !flush_en && !reset;
      // The head slot (output register or pending read) is occupied
      // unless it is being consumed this cycle.
      holding = (out_valid || in_flight) && !deq_acc;
      // With mem_count == 0 an accepted enqueue is read straight back
      // through the SRAM's NEW_DATA read-during-write path.
      read_issue = ((mem_count != CNT_ZERO) || enq_acc)
                && !holding && !flush_en && !reset;
   end

   assign sram_read_en    = read_issue;
   assign sram_read_addr  = rd_ptr;
   assign sram_write_en   = enq_acc;
   assign sram_write_addr = wr_ptr;
   assign sram_write_data = enqueue_value;

   always_ff @(posedge clk) begin
      if (reset || flush_en) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         mem_count <= '0;
         in_flight <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         if (enq_acc)
            wr_ptr <= wr_ptr + PTR_ONE;
         if (read_issue)
            rd_ptr <= rd_ptr + PTR_ONE;
         if (enq_acc && !read_issue)
            mem_count <= mem_count + CNT_ONE;
         else if (!enq_acc && read_issue)
            mem_count <= mem_count - CNT_ONE;
         in_flight <= read_issue;
         out_valid <= holding;
      end
   end

   // Returned read data is parked here when the head is not consumed.
   always_ff @(posedge clk) begin
      if (in_flight && !deq_acc)
         out_reg <= sram_read_data;
   end

endmodule

// File: tb/tb_sram_fifo.sv
// tb_sram_fifo: directed stimulus with a queue scoreboard; a negedge
// monitor checks status and popped data of sram_fifo against the queue.
module tb_sram_fifo;

   localparam int DW   = 32;
   localparam int SZ   = 64;
   localparam int AW   = 6;
   localparam int AFTH = SZ - 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          flush_en;
   logic          enqueue_en;
   logic [DW-1:0] enqueue_value;
   logic          dequeue_en;
   logic [DW-1:0] dequeue_value;
   logic          empty;
   logic          full;
   logic          almost_full;
   logic [AW:0]   count;
   logic          sram_read_en;
   logic [AW-1:0] sram_read_addr;
   logic [DW-1:0] sram_read_data;
   logic          sram_write_en;
   logic [AW-1:0] sram_write_addr;
   logic [DW-1:0] sram_write_data;

   logic [DW-1:0] mem [SZ];
   logic [DW-1:0] exp_q [$];
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sram_fifo #(
      .DATA_WIDTH(DW),
      .SIZE(SZ)
   ) dut (
      .clk(clk),
      .reset(reset),
      .flush_en(flush_en),
      .enqueue_en(enqueue_en),
      .enqueue_value(enqueue_value),
      .dequeue_en(dequeue_en),
      .dequeue_value(dequeue_value),
      .empty(empty),
      .full(full),
      .almost_full(almost_full),
      .count(count),
      .sram_read_en(sram_read_en),
      .sram_read_addr(sram_read_addr),
      .sram_read_data(sram_read_data),
      .sram_write_en(sram_write_en),
      .sram_write_addr(sram_write_addr),
      .sram_write_data(sram_write_data)
   );

   // 1r1w SRAM, 1-cycle read latency, NEW_DATA on same-address collision
   initial for (int i = 0; i < SZ; i++) mem[i] = '0;
   always @(posedge clk) begin
      if (sram_write_en)
         mem[sram_write_addr] <= sram_write_data;
      if (sram_read_en)
         sram_read_data <= (sram_write_en && sram_write_addr == sram_read_addr)
                           ? sram_write_data : mem[sram_read_addr];
   end

   // Monitor
   always @(negedge clk) begin
      logic [DW-1:0] e;
      int n;
      if (reset !== 1'b1) begin
         n = exp_q.size();
         checks++;
         if (int'(count) != n) begin
            errors++;
            $display("FAIL count got %0d want %0d t=%0t", count, n, $time);
         end
         checks++;
         if (empty !== (n == 0)) begin
            errors++;
            $display("FAIL empty got %b want %b t=%0t", empty, n == 0, $time);
         end
         checks++;
         if (full !== (n == SZ)) begin
            errors++;
            $display("FAIL full got %b want %b t=%0t", full, n == SZ, $time);
         end
         checks++;
         if (almost_full !== (n >= AFTH)) begin
            errors++;
            $display("FAIL almost_full got %b want %b t=%0t",
                     almost_full, n >= AFTH, $time);
         end
         checks++;
         if (dut.in_flight && dut.out_valid) begin
            errors++;
            $display("FAIL invariant got in_flight=1 out_valid=1 want not both");
         end
         if (dequeue_en && !flush_en && empty === 1'b0) begin
            checks++;
            if (n == 0) begin
               errors++;
               $display("FAIL pop got %h want no entry", dequeue_value);
            end else begin
               e = exp_q.pop_front();
               if (dequeue_value !== e) begin
                  errors++;
                  $display("FAIL data got %h want %h t=%0t",
                           dequeue_value, e, $time);
               end
            end
         end
      end
   end

   task automatic cyc(input bit e, input logic [DW-1:0] v,
                      input bit d, input bit f);
      bit ea;
      enqueue_en    = e;
      enqueue_value = v;
      dequeue_en    = d;
      flush_en      = f;
      ea = e && !f && (exp_q.size() < SZ);
      @(posedge clk);
      if (f)
         exp_q.delete();
      else if (ea)
         exp_q.push_back(v);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      enqueue_en = 1'b0;
      dequeue_en = 1'b0;
      flush_en   = 1'b0;
      @(posedge clk);
      exp_q.delete();
      #1;
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      flush_en = 1'b0;
      enqueue_en = 1'b0;
      enqueue_value = '0;
      dequeue_en = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      do_reset();
      cyc(0, 0, 0, 0);

      // single entry latency
      cyc(1, 32'hA5, 0, 0);
      cyc(0, 0, 0, 0);
      cyc(0, 0, 1, 0);
      cyc(0, 0, 1, 0);

      // enqueue and dequeue while empty: only the enqueue happens
      cyc(1, 32'h8, 1, 0);
      cyc(0, 0, 1, 0);

      // fill to full, overflow attempts, then drain
      for (int i = 1; i <= SZ; i++) cyc(1, DW'(i), 0, 0);
      cyc(1, 32'd99, 0, 0);
      cyc(1, 32'd100, 1, 0);
      for (int i = 0; i < SZ + 4; i++) cyc(0, 0, 1, 0);

      // steady streaming with 10 entries held
      for (int i = 0; i < 10; i++) cyc(1, 32'h500 + DW'(i), 0, 0);
      for (int i = 0; i < 200; i++) cyc(1, 32'h1000 + DW'(i), 1, 0);
      for (int i = 0; i < 12; i++) cyc(0, 0, 1, 0);

      // hold dequeue while reads are pending
      cyc(1, 32'h31, 0, 0);
      cyc(1, 32'h32, 0, 0);
      cyc(1, 32'h33, 0, 0);
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);
      for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0);

      // flush with enqueue and dequeue
      for (int i = 0; i < 20; i++) cyc(1, 32'h200 + DW'(i), 0, 0);
      cyc(1, 32'h55, 1, 1);
      cyc(0, 0, 0, 0);
      cyc(1, 32'h7, 0, 0);
      cyc(0, 0, 1, 0);
      cyc(0, 0, 1, 0);

      // reset with count 5 and a read in flight
      for (int i = 0; i < 6; i++) cyc(1, 32'h600 + DW'(i), 0, 0);
      cyc(0, 0, 1, 0);
      do_reset();
      cyc(0, 0, 0, 0);
      cyc(0, 0, 1, 0);
      cyc(1, 32'h77, 0, 0);
      cyc(0, 0, 1, 0);
      cyc(0, 0, 0, 0);

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL leftover got %0d want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sram_fifo.md
SRAM_FIFO -- requirements
Module: sram_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 32, entry width in bits.
REQ-002 Parameter SIZE, default 64, capacity in entries; power of two, at least 4.
REQ-003 Parameter ALMOST_FULL_THRESHOLD, default SIZE-4, count at which almost_full asserts.
REQ-004 Parameter ADDR_WIDTH, default $clog2(SIZE), derived SRAM address width.
REQ-005 One clock, clk; reset is synchronous and active-high, named reset.
REQ-006 Ports SHALL be:
- clk  input  1  clock.
- reset  input  1  synchronous active-high reset.
- flush_en  input  1  discard all contents.
- enqueue_en  input  1  push enqueue_value.
- enqueue_value  input  DATA_WIDTH  push data.
- dequeue_en  input  1  pop head.
- dequeue_value  output  DATA_WIDTH  head entry, first-word-fall-through.
- empty  output  1  no head available.
- full  output  1  count == SIZE.
- almost_full  output  1  count >= ALMOST_FULL_THRESHOLD.
- count  output  ADDR_WIDTH+1  total entries held.
- sram_read_en  output  1  to 1r1w macro wrapper read_en.
- sram_read_addr  output  ADDR_WIDTH  to read_addr.
- sram_read_data  input  DATA_WIDTH  from read_data, valid cycle after sram_read_en.
- sram_write_en  output  1  to write_en.
- sram_write_addr  output  ADDR_WIDTH  to write_addr.
- sram_write_data  output  DATA_WIDTH  to write_data.

Function
REQ-007 Block drives an external 1r1w SRAM with 1-cycle read latency and NEW_DATA read-during-write.
REQ-008 State: write pointer wr_ptr, read pointer rd_ptr (ADDR_WIDTH bits, natural wrap SIZE-1 -> 0), mem_count (entries in SRAM), in_flight (read issued last cycle), out_valid (head held in output register).
REQ-009 Invariant: in_flight and out_valid are never both 1.
REQ-010 Enqueue accepted iff enqueue_en && !full && !flush_en; the push drives sram_write_en=1, sram_write_addr=wr_ptr, sram_write_data=enqueue_value, and wr_ptr increments.
REQ-011 Dequeue accepted iff dequeue_en && !empty && !flush_en; dequeue while empty is ignored.
REQ-012 empty = !(out_valid || in_flight); dequeue_value = out_valid ? output register : sram_read_data.
REQ-013 Read issue: sram_read_en=1, sram_read_addr=rd_ptr when (mem_count>0 || accepted enqueue) && (out_valid+in_flight-accepted dequeue)==0 && !flush_en; rd_ptr increments and in_flight is set next cycle.
REQ-014 Same-cycle read of the address being written is legal; NEW_DATA returns the written value.
REQ-015 in_flight with no dequeue: sram_read_data captured into output register, out_valid=1 next cycle.
REQ-016 mem_count next = mem_count + accepted enqueue - read issue; count = mem_count + out_valid + in_flight.
REQ-017 full and enqueue_en in the same cycle: enqueue ignored even if a dequeue is accepted that cycle; empty with enqueue and dequeue both asserted: enqueue accepted, dequeue ignored.
REQ-018 Latency: an enqueue into an empty FIFO deasserts empty the next cycle; sustained throughput is one enqueue and one dequeue per cycle.
REQ-019 flush_en clears pointers, mem_count, in_flight and out_valid next cycle; enqueue and dequeue in the flush cycle are ignored; SRAM contents are not cleared.
REQ-020 full, almost_full and count derive from registered state only; no combinational path from enqueue_en or dequeue_en to them.

Reset
REQ-021 While reset is high at a clk edge: wr_ptr=0, rd_ptr=0, mem_count=0, in_flight=0, out_valid=0; next cycle empty=1, full=0, almost_full=0, count=0, sram_read_en=0, sram_write_en=0.
REQ-022 Reset mid-operation discards all entries, including an in-flight read; its returned data is never presented.

Verification
REQ-023 Reset; enqueue 0xA5 at cycle 0 -> cycle 1: empty=0, dequeue_value=0xA5, count=1.
REQ-024 Enqueue 1..64 back-to-back with SIZE=64 -> full=1 after the 64th; almost_full from count 60; 65th enqueue ignored, count stays 64.
REQ-025 Fill 10 entries, then enqueue and dequeue every cycle for 200 cycles -> values dequeue in order, count stays 10, no bubbles, pointers wrap.
REQ-026 Hold dequeue_en low while a read is in flight, then dequeue 3 times -> values captured and returned in order, invariant REQ-009 holds.
REQ-027 Fill 20, assert flush_en with enqueue_en -> next cycle empty=1, count=0; a subsequent enqueue of 0x7 is the next head.
REQ-028 Assert reset while count=5 and a read is in flight -> next cycle empty=1, count=0; stale SRAM data never appears on dequeue_value.
